// File: rtl/spart_pkg.sv
// spart_pkg: shared SPART constants, CPU address map and framer state encoding
package spart_pkg;
    localparam int NUM_NIB = 15;
    localparam logic [3:0] TERM_TAG = 4'hF;
    localparam logic [7:0] BAUD_RATE = 8'h50;
    localparam logic [2:0] ADDR_START = 3'd0;
    localparam logic [2:0] ADDR_N0 = 3'd1;
    localparam logic [2:0] ADDR_N1_4 = 3'd2;
    localparam logic [2:0] ADDR_N5_8 = 3'd3;
    localparam logic [2:0] ADDR_N9_12 = 3'd4;
    localparam logic [2:0] ADDR_N13_14 = 3'd5;
    typedef enum logic [1:0] {IDLE, DATA, TERM, DONE} state_t;
endpackage

// File: rtl/spart_tx_framer_if.sv
// spart_tx_framer_if: CPU write port plus FIFO push port of the SPART transmit framer
interface spart_tx_framer_if;
    logic wr;
    logic [2:0] addr;
    logic [15:0] wdata;
    logic full;
    logic send;
    logic [7:0] data_out;
    logic busy;
    logic done;
    modport master (output wr, addr, wdata, full, input send, data_out, busy, done);
    modport slave (input wr, addr, wdata, full, output send, data_out, busy, done);
endinterface

// File: rtl/spart_nib_regfile.sv
// spart_nib_regfile: address-decoded 15x4 nibble store with a read port indexed by idx
import spart_pkg::*;
module spart_nib_regfile (
    input logic clk,
    input logic rst,
    input logic wr,
    input logic [2:0] addr,
    input logic [15:0] wdata,
    input logic [3:0] idx,
    output logic [3:0] nib
);
    logic [3:0] r [NUM_NIB];
    always_ff @(posedge clk or posedge rst)
        if (rst)
            for (int i = 0; i < NUM_NIB; i++) r[i] <= '0;
        else if (wr)
            case (addr)
                ADDR_N0: r[0] <= wdata[3:0];
                ADDR_N1_4: {r[1], r[2], r[3], r[4]} <= wdata;
                ADDR_N5_8: {r[5], r[6], r[7], r[8]} <= wdata;
                ADDR_N9_12: {r[9], r[10], r[11], r[12]} <= wdata;
                ADDR_N13_14: {r[13], r[14]} <= wdata[7:0];
                default: ;
            endcase
    // idx runs one past the last nibble while the terminator is out
    assign nib = (idx < 4'(NUM_NIB)) ? r[idx] : '0;
endmodule

// File: rtl/spart_tx_framer.sv
// spart_tx_framer: pushes {idx,nib} bytes plus a 0xF terminator into the SPART TX FIFO
// SPART_TX_FRAMER_CKSUM_EN: terminator low nibble carries the XOR of all data nibbles
import spart_pkg::*;
module spart_tx_framer (
    input logic clk,
    input logic rst,
    spart_tx_framer_if.slave bus
);
    state_t state, state_nx;
    logic [3:0] idx, nib, tail;
    logic idle, start, acc, data_acc;
    assign idle = state == IDLE;
    assign start = idle && bus.wr && bus.addr == ADDR_START;
    assign acc = (state == DATA || state == TERM) && !bus.full;
    assign data_acc = acc && state == DATA;
    spart_nib_regfile u_regs (
        .clk(clk),
        .rst(rst),
        .wr(idle && bus.wr),
        .addr(bus.addr),
        .wdata(bus.wdata),
        .idx(idx),
        .nib(nib)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;
    always_ff @(posedge clk or posedge rst)
        if (rst) idx <= '0;
        else if (start) idx <= '0;
        else if (data_acc) idx <= idx + 4'd1;
`ifdef SPART_TX_FRAMER_CKSUM_EN
    logic [3:0] cks;
    always_ff @(posedge clk or posedge rst)
        if (rst) cks <= '0;
        else if (start) cks <= '0;
        else if (data_acc) cks <= cks ^ nib;
    assign tail = cks;
`else
    assign tail = '0;
`endif
    always_comb begin
        state_nx = state;
        bus.data_out = '0;
        bus.done = 1'b0;
        case (state)
            IDLE: state_nx = start ? DATA : IDLE;
            DATA: begin
                bus.data_out = {idx, nib};
                state_nx = (acc && idx == 4'(NUM_NIB - 1)) ? TERM : DATA;
            end
            TERM: begin
                bus.data_out = {TERM_TAG, tail};
                state_nx = acc ? DONE : TERM;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    assign bus.send = acc;
    assign bus.busy = !idle;
endmodule

// File: tb/tb_spart_tx_framer.sv
// tb_spart_tx_framer: randomized self-checking bench against a frame-level reference model
import spart_pkg::*;
module tb_spart_tx_framer;
    logic clk = 1'b0;
    logic rst;
    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [7:0] got [$];
    logic [3:0] m_nib [15];

    spart_tx_framer_if bus ();
    spart_tx_framer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst) begin
            if (bus.send) got.push_back(bus.data_out);
            if (bus.done) done_cnt++;
        end

    function automatic void m_clear();
        for (int i = 0; i < 15; i++) m_nib[i] = 4'h0;
    endfunction

    function automatic void m_write(input logic [2:0] a, input logic [15:0] d);
        if (a == 3'd1) m_nib[0] = d[3:0];
        else if (a >= 3'd2 && a <= 3'd4)
            for (int k = 0; k < 4; k++) m_nib[1 + 4 * (int'(a) - 2) + k] = d[15 - 4 * k -: 4];
        else if (a == 3'd5) begin
            m_nib[13] = d[7:4];
            m_nib[14] = d[3:0];
        end
    endfunction

    function automatic logic [7:0] m_byte(input int i);
        logic [3:0] x;
        x = 4'h0;
        if (i < 15) return {4'(i), m_nib[i]};
        for (int k = 0; k < 15; k++) x = x ^ m_nib[k];
`ifdef SPART_TX_FRAMER_CKSUM_EN
        return {4'hF, x};
`else
        return 8'hF0;
`endif
    endfunction

    task automatic cpu_wr(input logic [2:0] a, input logic [15:0] d);
        bus.wr = 1'b1;
        bus.addr = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.wr = 1'b0;
    endtask

    task automatic load(input logic [2:0] a, input logic [15:0] d);
        cpu_wr(a, d);
        m_write(a, d);
    endtask

    task automatic load_plan();
        load(3'd1, 16'h0007);
        load(3'd2, 16'h1234);
        load(3'd3, 16'h5678);
        load(3'd4, 16'h9ABC);
        load(3'd5, 16'h00DE);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int c0;
        c0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt != c0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.wr = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        bus.full = 1'b0;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if ({bus.send, bus.busy, bus.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 000", {bus.send, bus.busy, bus.done});
        end
        n_chk++;
        if (bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data got %h exp 00", bus.data_out);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        load_plan();
        got.delete();
        cpu_wr(ADDR_START, 16'h0);
        for (int i = 0; i < 16; i++) begin
            n_chk++;
            if (bus.send !== 1'b1 || bus.data_out !== m_byte(i)) begin
                n_fail++;
                $display("FAIL basic_byte%0d got send=%b %h exp send=1 %h", i, bus.send, bus.data_out, m_byte(i));
            end
            @(posedge clk);
            #1;
        end
        n_chk++;
        if ({bus.done, bus.busy, bus.send} !== 3'b110) begin
            n_fail++;
            $display("FAIL basic_done got done/busy/send=%b exp 110", {bus.done, bus.busy, bus.send});
        end
        @(posedge clk);
        #1;
        n_chk++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_idle got done/busy=%b exp 00", {bus.done, bus.busy});
        end
        n_chk++;
        if (got.size() !== 16) begin
            n_fail++;
            $display("FAIL basic_count got %0d exp 16", got.size());
        end
    endtask

    task automatic test_stall();
        bit ok;
        got.delete();
        cpu_wr(ADDR_START, 16'h0);
        repeat (4) @(posedge clk);
        #1;
        bus.full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_chk++;
            if (bus.send !== 1'b0 || bus.data_out !== 8'h44 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold%0d got send=%b %h busy=%b exp send=0 44 busy=1", c, bus.send, bus.data_out, bus.busy);
            end
            @(posedge clk);
            #1;
        end
        bus.full = 1'b0;
        wait_done(40, ok);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_timeout got no done exp done");
        end
        n_chk++;
        if (got.size() !== 16) begin
            n_fail++;
            $display("FAIL stall_count got %0d exp 16", got.size());
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_chk++;
            if (got[i] !== m_byte(i)) begin
                n_fail++;
                $display("FAIL stall_byte%0d got %h exp %h", i, got[i], m_byte(i));
            end
        end
    endtask

    task automatic test_busy_writes();
        bit ok;
        int d0;
        got.delete();
        d0 = done_cnt;
        cpu_wr(ADDR_START, 16'h0);
        cpu_wr(3'd2, 16'hFFFF);
        cpu_wr(ADDR_START, 16'h0);
        wait_done(40, ok);
        repeat (25) @(posedge clk);
        #1;
        n_chk++;
        if (!ok || done_cnt - d0 !== 1 || got.size() !== 16) begin
            n_fail++;
            $display("FAIL busy_single got done=%0d bytes=%0d exp done=1 bytes=16", done_cnt - d0, got.size());
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_chk++;
            if (got[i] !== m_byte(i)) begin
                n_fail++;
                $display("FAIL busy_byte%0d got %h exp %h", i, got[i], m_byte(i));
            end
        end
        got.delete();
        cpu_wr(ADDR_START, 16'h0);
        wait_done(40, ok);
        n_chk++;
        if (!ok || got.size() !== 16) begin
            n_fail++;
            $display("FAIL resend_count got %0d exp 16", got.size());
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_chk++;
            if (got[i] !== m_byte(i)) begin
                n_fail++;
                $display("FAIL resend_byte%0d got %h exp %h", i, got[i], m_byte(i));
            end
        end
    endtask

    task automatic test_full_hold();
        bit ok;
        got.delete();
        bus.full = 1'b1;
        cpu_wr(ADDR_START, 16'h0);
        for (int c = 0; c < 100; c++) begin
            n_chk++;
            if (bus.send !== 1'b0 || bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_wait%0d got send=%b busy=%b exp send=0 busy=1", c, bus.send, bus.busy);
            end
            @(posedge clk);
            #1;
        end
        bus.full = 1'b0;
        #1;
        n_chk++;
        if (bus.send !== 1'b1 || bus.data_out !== 8'h07) begin
            n_fail++;
            $display("FAIL hold_first got send=%b %h exp send=1 07", bus.send, bus.data_out);
        end
        wait_done(40, ok);
        n_chk++;
        if (!ok || got.size() !== 16) begin
            n_fail++;
            $display("FAIL hold_count got %0d exp 16", got.size());
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_chk++;
            if (got[i] !== m_byte(i)) begin
                n_fail++;
                $display("FAIL hold_byte%0d got %h exp %h", i, got[i], m_byte(i));
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        bit term_seen;
        got.delete();
        cpu_wr(ADDR_START, 16'h0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.send, bus.busy, bus.done} !== 3'b000 || bus.data_out !== 8'h00) begin
            n_fail++;
            $display("FAIL midrst_out got send/busy/done=%b %h exp 000 00", {bus.send, bus.busy, bus.done}, bus.data_out);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_clear();
        repeat (20) @(posedge clk);
        #1;
        term_seen = 1'b0;
        foreach (got[i]) if (got[i][7:4] == 4'hF) term_seen = 1'b1;
        n_chk++;
        if (got.size() !== 8 || term_seen) begin
            n_fail++;
            $display("FAIL midrst_abandon got bytes=%0d term=%b exp bytes=8 term=0", got.size(), term_seen);
        end
        got.delete();
        cpu_wr(ADDR_START, 16'h0);
        wait_done(40, ok);
        n_chk++;
        if (!ok || got.size() !== 16) begin
            n_fail++;
            $display("FAIL midrst_count got %0d exp 16", got.size());
        end
        for (int i = 0; i < got.size() && i < 16; i++) begin
            n_chk++;
            if (got[i] !== m_byte(i)) begin
                n_fail++;
                $display("FAIL midrst_byte%0d got %h exp %h", i, got[i], m_byte(i));
            end
        end
    endtask

    task automatic test_loopback();
        bit ok;
        bit rx_flag;
        logic [3:0] rx [15];
        for (int i = 0; i < 15; i++) rx[i] = 4'h0;
        rx_flag = 1'b0;
        load_plan();
        got.delete();
        cpu_wr(ADDR_START, 16'h0);
        wait_done(40, ok);
        foreach (got[i])
            if (got[i][7:4] == 4'hF) rx_flag = 1'b1;
            else rx[got[i][7:4]] = got[i][3:0];
        n_chk++;
        if (!ok || !rx_flag || got.size() !== 16) begin
            n_fail++;
            $display("FAIL loop_flag got flag=%b bytes=%0d exp flag=1 bytes=16", rx_flag, got.size());
        end
        n_chk++;
        if ({rx[1], rx[2], rx[3], rx[4]} !== 16'h1234) begin
            n_fail++;
            $display("FAIL loop_addr2 got %h exp 1234", {rx[1], rx[2], rx[3], rx[4]});
        end
        n_chk++;
        if ({8'h00, rx[13], rx[14]} !== 16'h00DE) begin
            n_fail++;
            $display("FAIL loop_addr5 got %h exp 00de", {8'h00, rx[13], rx[14]});
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int it = 0; it < 4; it++) begin
            repeat (6) load(3'($urandom_range(1, 7)), 16'($urandom));
            got.delete();
            cpu_wr(ADDR_START, 16'h0);
            ok = 1'b0;
            for (int c = 0; c < 300 && !ok; c++) begin
                bus.full = ($urandom_range(0, 2) == 0);
                @(posedge clk);
                #1;
                ok = (done_cnt > 0) && !bus.busy;
            end
            bus.full = 1'b0;
            n_chk++;
            if (!ok || got.size() !== 16) begin
                n_fail++;
                $display("FAIL rand%0d_count got %0d exp 16", it, got.size());
            end
            for (int i = 0; i < got.size() && i < 16; i++) begin
                n_chk++;
                if (got[i] !== m_byte(i)) begin
                    n_fail++;
                    $display("FAIL rand%0d_byte%0d got %h exp %h", it, i, got[i], m_byte(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_busy_writes();
        test_full_hold();
        test_reset_midframe();
        test_loopback();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
